hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Hazard and interlock controller for the 5-stage pipelined CPU. It detects load-use hazards and HI/LO accesses that collide with an in-flight multi-cycle multiply/divide, and freezes PC and IF/ID. It drives the select of the ID/EX control-bubble mux so a zeroed control word enters EX, and squashes IF/ID on a taken branch. It sits beside the ID stage and holds the only sequential state for multiply/divide occupancy.

## Interface
- `MULDIV_CYCLES`, default 32: EX-side multiply/divide latency in cycles. Legal range 1 to 2^CNT_W-1.
- `CNT_W`, default 6: width of the occupancy counter.

- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `IdRs`  in  5  rs field of the instruction in ID.
- `IdRt`  in  5  rt field of the instruction in ID.
- `IdUsesRt`  in  1  ID instruction reads rt as a source.
- `IdHiLoUse`  in  1  ID instruction reads or writes HI/LO (mfhi, mflo, mthi, mtlo, mult, multu, div, divu).
- `ExMemRead`  in  1  instruction in EX is a load.
- `ExRt`  in  5  destination rt of the instruction in EX.
- `ExHiLoEnable`  in  1  mult/div is issuing in EX this cycle (post-bubble-mux value).
- `BranchTaken`  in  1  branch/jump resolved taken in ID this cycle.
- `PCWrite`  out  1  PC load enable.
- `IfIdWrite`  out  1  IF/ID register load enable.
- `IfIdFlush`  out  1  clear IF/ID to a nop on the next edge.
- `HazardMuxSelect`  out  1  1 = insert bubble (zero WB/M/EX control) into ID/EX.
- `MulDivBusy`  out  1  multiply/divide unit occupied.

## Operation
- State register: `IDLE` or `BUSY`. There is also a `CNT_W`-bit counter `cnt`.
- `loaduse` = ExMemRead & (ExRt != 0) & ((ExRt == IdRs) | (IdUsesRt & ExRt == IdRt)).
- `hilo_stall` = (state == BUSY) & IdHiLoUse.
- `stall` = loaduse | hilo_stall.
- Outputs are combinational from state and inputs:
  - PCWrite = IfIdWrite = ~stall.
  - HazardMuxSelect = stall.
  - IfIdFlush = BranchTaken & ~stall. A branch held in ID by a stall is not acted on; it re-resolves when released.
  - MulDivBusy = (state == BUSY).
- `IDLE` to `BUSY`: ExHiLoEnable = 1 at the edge; `cnt` loads MULDIV_CYCLES.
- In `BUSY`, `cnt` decrements every edge. At the edge where `cnt` == 1, the state returns to `IDLE` and `cnt` becomes 0.
- ExHiLoEnable in `BUSY` is ignored; it is unreachable, because hilo_stall bubbles the mult/div in ID.
- ExHiLoEnable and `cnt` reaching 1 on the same edge are mutually exclusive for the same reason.
- Register $0 never creates a load-use hazard.
- loaduse and hilo_stall together produce a single stall. There is no double counting and no extra cycle.

## Timing
- Reset: state = IDLE, cnt = 0.
- While reset = 1, outputs are forced to PCWrite = 1, IfIdWrite = 1, IfIdFlush = 0, HazardMuxSelect = 0, MulDivBusy = 0, regardless of other inputs.
- Reset asserted in `BUSY` aborts occupancy; MulDivBusy = 0 in the first cycle after reset deasserts.
- Load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM, ExMemRead deasserts and the hazard clears.
- Multiply/divide: ExHiLoEnable high in cycle T gives MulDivBusy high for cycles T+1 through T+MULDIV_CYCLES. It is low at T+MULDIV_CYCLES+1.
- An ID HI/LO user waiting on the multiply/divide is released in cycle T+MULDIV_CYCLES+1.
- MULDIV_CYCLES = 1 gives one busy cycle.
- Stall outputs have zero latency: they assert in the same cycle as the triggering inputs.

## Configuration
- `HAZARD_MULDIV_INTERLOCK_EN`
  - Defined: the IDLE/BUSY state machine and counter are built as described above.
  - Undefined: state and counter are not instantiated. MulDivBusy is tied 0 and hilo_stall is 0, for a single-cycle HI/LO datapath. Load-use detection and branch flush are unchanged.

## Test plan
- Load-use on rs: ExMemRead = 1, ExRt = 5, IdRs = 5.
  - Required: for exactly one cycle, HazardMuxSelect = 1, PCWrite = 0, IfIdWrite = 0.
  - Next cycle with ExMemRead = 0: all return to normal.
- $0 and rt gating:
  - ExRt = 0, IdRs = 0, ExMemRead = 1 → no stall.
  - ExRt = 7, IdRt = 7, IdUsesRt = 0 → no stall.
  - Same with IdUsesRt = 1 → stall.
- Multiply/divide occupancy with MULDIV_CYCLES = 4: ExHiLoEnable pulse at T.
  - Required: MulDivBusy = 1 for T+1 to T+4.
  - IdHiLoUse = 1 held from T+1 gives stall through T+4 and release at T+5.
- Branch under stall: BranchTaken = 1 with loaduse = 1 → IfIdFlush = 0. Next cycle, BranchTaken = 1 with no hazard → IfIdFlush = 1, PCWrite = 1.
- Reset mid-busy: MULDIV_CYCLES = 32, reset at T+10.
  - Required: during reset, outputs take their forced reset values.
  - After release, MulDivBusy = 0 and there is no HI/LO stall.
- Build without `HAZARD_MULDIV_INTERLOCK_EN`: an ExHiLoEnable pulse followed by IdHiLoUse = 1 produces no stall and MulDivBusy = 0 throughout.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use and HI/LO interlock detection for the 5-stage pipeline.
// Freezes PC and IF/ID, selects the ID/EX control bubble, and squashes IF/ID on
// a taken branch. It holds the only state tracking multiply/divide occupancy.
// Optional feature macro: HAZARD_MULDIV_INTERLOCK_EN builds the IDLE/BUSY
// occupancy tracker. Without it, HI/LO is treated as single-cycle:
// MulDivBusy stays 0 and HI/LO accesses never stall.
// Handshake/timing: all stall outputs are combinational from inputs and state
// (zero latency). While reset is high the outputs are forced to their
// free-running values.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IdRs,
  input  logic [4:0] IdRt,
  input  logic       IdUsesRt,
  input  logic       IdHiLoUse,
  input  logic       ExMemRead,
  input  logic [4:0] ExRt,
  input  logic       ExHiLoEnable,
  input  logic       BranchTaken,
  output logic       PCWrite,
  output logic       IfIdWrite,
  output logic       IfIdFlush,
  output logic       HazardMuxSelect,
  output logic       MulDivBusy
);

  logic loaduse;
  logic hilo_stall;
  logic stall;
  logic busy;

  // Load in EX whose destination feeds a source of the ID instruction; $0 is exempt.
  always_comb begin
    loaduse = ExMemRead && (ExRt != 5'd0) &&
              ((ExRt == IdRs) || (IdUsesRt && (ExRt == IdRt)));
  end

`ifdef HAZARD_MULDIV_INTERLOCK_EN
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: start on a mult/div issue, count down, return to IDLE on the last cycle.
  // An issue seen while BUSY cannot happen (the HI/LO user is bubbled), so it is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ExHiLoEnable) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Occupancy registers; reset aborts any in-flight multiply/divide.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Busy flag seen by the stall logic and the MulDivBusy output.
  always_comb begin
    busy       = (state_q == BUSY);
    hilo_stall = busy && IdHiLoUse;
  end
`else
  logic unused_muldiv;

  // Single-cycle HI/LO datapath: never busy, never a HI/LO stall.
  always_comb begin
    busy          = 1'b0;
    hilo_stall    = 1'b0;
    unused_muldiv = clk ^ ExHiLoEnable ^ IdHiLoUse;
  end
`endif

  // Output decode; a combined load-use and HI/LO hazard is still one stall.
  always_comb begin
    stall = loaduse || hilo_stall;
    if (reset) begin
      PCWrite         = 1'b1;
      IfIdWrite       = 1'b1;
      IfIdFlush       = 1'b0;
      HazardMuxSelect = 1'b0;
      MulDivBusy      = 1'b0;
    end else begin
      PCWrite         = !stall;
      IfIdWrite       = !stall;
      IfIdFlush       = BranchTaken && !stall;
      HazardMuxSelect = stall;
      MulDivBusy      = busy;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl. Three instances
// (MULDIV_CYCLES = 4, 32, 1) share the same stimulus; a reference model of
// occupancy produces expected outputs that go through a scoreboard queue.
module tb_hazard_ctrl;

`ifdef HAZARD_MULDIV_INTERLOCK_EN
  localparam bit INTERLOCK = 1'b1;
`else
  localparam bit INTERLOCK = 1'b0;
`endif

  localparam int N0 = 4;
  localparam int N1 = 32;
  localparam int N2 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [4:0] IdRs = '0, IdRt = '0, ExRt = '0;
  logic       IdUsesRt = 1'b0, IdHiLoUse = 1'b0, ExMemRead = 1'b0;
  logic       ExHiLoEnable = 1'b0, BranchTaken = 1'b0;

  logic [4:0] o0, o1, o2;  // {PCWrite, IfIdWrite, IfIdFlush, HazardMuxSelect, MulDivBusy}

  hazard_ctrl #(.MULDIV_CYCLES(N0), .CNT_W(6)) u_dut4 (
    .clk(clk), .reset(reset), .IdRs(IdRs), .IdRt(IdRt), .IdUsesRt(IdUsesRt),
    .IdHiLoUse(IdHiLoUse), .ExMemRead(ExMemRead), .ExRt(ExRt),
    .ExHiLoEnable(ExHiLoEnable), .BranchTaken(BranchTaken),
    .PCWrite(o0[4]), .IfIdWrite(o0[3]), .IfIdFlush(o0[2]),
    .HazardMuxSelect(o0[1]), .MulDivBusy(o0[0]));

  hazard_ctrl #(.MULDIV_CYCLES(N1), .CNT_W(6)) u_dut32 (
    .clk(clk), .reset(reset), .IdRs(IdRs), .IdRt(IdRt), .IdUsesRt(IdUsesRt),
    .IdHiLoUse(IdHiLoUse), .ExMemRead(ExMemRead), .ExRt(ExRt),
    .ExHiLoEnable(ExHiLoEnable), .BranchTaken(BranchTaken),
    .PCWrite(o1[4]), .IfIdWrite(o1[3]), .IfIdFlush(o1[2]),
    .HazardMuxSelect(o1[1]), .MulDivBusy(o1[0]));

  hazard_ctrl #(.MULDIV_CYCLES(N2), .CNT_W(6)) u_dut1 (
    .clk(clk), .reset(reset), .IdRs(IdRs), .IdRt(IdRt), .IdUsesRt(IdUsesRt),
    .IdHiLoUse(IdHiLoUse), .ExMemRead(ExMemRead), .ExRt(ExRt),
    .ExHiLoEnable(ExHiLoEnable), .BranchTaken(BranchTaken),
    .PCWrite(o2[4]), .IfIdWrite(o2[3]), .IfIdFlush(o2[2]),
    .HazardMuxSelect(o2[1]), .MulDivBusy(o2[0]));

  // ---------------- reference model ----------------
  // left_N = remaining busy cycles visible to the instance with latency N.
  int left0 = 0, left1 = 0, left2 = 0;

  always @(posedge clk) begin
    if (reset) begin
      left0 <= 0;
      left1 <= 0;
      left2 <= 0;
    end else begin
      if (left0 > 0) left0 <= left0 - 1; else if (ExHiLoEnable) left0 <= N0;
      if (left1 > 0) left1 <= left1 - 1; else if (ExHiLoEnable) left1 <= N1;
      if (left2 > 0) left2 <= left2 - 1; else if (ExHiLoEnable) left2 <= N2;
    end
  end

  function automatic logic [4:0] model_out(input int left);
    logic busy_m, lu, st;
    busy_m = INTERLOCK && (left > 0);
    lu = ExMemRead && (ExRt != 5'd0) &&
         ((ExRt == IdRs) || (IdUsesRt && (ExRt == IdRt)));
    st = lu || (busy_m && IdHiLoUse);
    if (reset) return 5'b11000;
    return {!st, !st, BranchTaken && !st, st, busy_m};
  endfunction

  // ---------------- scoreboard ----------------
  logic [14:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic rst,
                      input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                      input logic hilo, input logic mr, input logic [4:0] ex_rt,
                      input logic hi_en, input logic br);
    logic [14:0] exp_v, obs_v;
    @(negedge clk);
    reset = rst; IdRs = rs; IdRt = rt; IdUsesRt = uses_rt; IdHiLoUse = hilo;
    ExMemRead = mr; ExRt = ex_rt; ExHiLoEnable = hi_en; BranchTaken = br;
    #1;
    exp_q.push_back({model_out(left0), model_out(left1), model_out(left2)});
    #2;
    obs_v = {o0, o1, o2};
    exp_v = exp_q.pop_front();
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b_%b_%b expected %b_%b_%b", tag,
             obs_v[14:10], obs_v[9:5], obs_v[4:0], exp_v[14:10], exp_v[9:5], exp_v[4:0]);
    end
  endtask

  task automatic idle(input string tag, input logic hilo);
    step(tag, 1'b0, 5'd0, 5'd0, 1'b0, hilo, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with hazards present: outputs must be forced.
    step("reset_forced_a", 1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 1, 1);
    step("reset_forced_b", 1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 1);
    idle("after_reset", 1'b1);

    // Load-use on rs, then clears.
    step("loaduse_rs",      0, 5'd5, 5'd0, 0, 0, 1, 5'd5, 0, 0);
    step("loaduse_cleared", 0, 5'd5, 5'd0, 0, 0, 0, 5'd5, 0, 0);

    // $0 and rt gating.
    step("r0_no_stall",        0, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0);
    step("rt_not_used",        0, 5'd3, 5'd7, 0, 0, 1, 5'd7, 0, 0);
    step("rt_used",            0, 5'd3, 5'd7, 1, 0, 1, 5'd7, 0, 0);
    step("no_load_no_stall",   0, 5'd7, 5'd7, 1, 0, 0, 5'd7, 0, 0);

    // Branch held by a stall, then acted on.
    step("branch_under_stall", 0, 5'd9, 5'd0, 0, 0, 1, 5'd9, 0, 1);
    step("branch_flush",       0, 5'd9, 5'd0, 0, 0, 0, 5'd9, 0, 1);

    // Multiply/divide occupancy: pulse at T, HI/LO user waits from T+1.
    step("muldiv_issue_T", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0);
    idle("muldiv_T1", 1'b1);
    step("muldiv_T2_loaduse_too", 0, 5'd4, 5'd0, 0, 1, 1, 5'd4, 0, 0);
    idle("muldiv_T3", 1'b1);
    idle("muldiv_T4", 1'b1);
    idle("muldiv_T5_release", 1'b1);
    idle("muldiv_T6", 1'b0);

    // Reset mid-busy (latency-32 instance still busy at T+10).
    step("midbusy_issue_T", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0);
    for (int i = 1; i < 10; i++) idle("midbusy_wait", 1'b1);
    step("midbusy_reset_a", 1, 5'd2, 5'd2, 1, 1, 1, 5'd2, 0, 1);
    step("midbusy_reset_b", 1, 5'd2, 5'd2, 1, 1, 0, 5'd0, 1, 0);
    idle("midbusy_released", 1'b1);
    step("midbusy_branch", 0, 5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 1);

    // Random traffic with a small register range to hit hazards often.
    for (int i = 0; i < 120; i++) begin
      step("random", ($urandom_range(0, 39) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    end

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: observed %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
